// File: rtl/hamming_secded_encoder_72bit.sv
// SECDED (72,64) extended Hamming encoder with MSB-first serializer.
// Ports: clk, reset (async, active-high); in_data/in_valid/in_ready
//   word handshake; serial_out/serial_valid/sof serial frame line;
//   check_out last check byte; busy in SHIFT/GAP; frames_sent count.
module hamming_secded_encoder_72bit #(
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             sof,
  output logic [7:0]       check_out,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [71:0]      r_sr;
  logic [6:0]       r_cnt;
  logic [15:0]      r_gap;
  logic             r_in_ready;
  logic             r_so;
  logic             r_sv;
  logic             r_sof;
  logic [7:0]       r_check;
  logic             r_busy;
  logic [CNT_W-1:0] r_frames;

  logic [6:0]       w_c;
  logic             w_p;
  logic [71:0]      w_cw;
  logic             w_accept;
  logic             w_last;
  logic             w_gap_done;
  logic             w_in_ready_n;
  logic             w_so_n;
  logic             w_sv_n;
  logic             w_sof_n;
  logic             w_busy_n;

  // Hamming position of data bit i: the i-th position in 3..71
  // that is not a power of two.
  function automatic logic [6:0] f_pos(input int i);
    int         n;
    logic [6:0] r;
    n = 0;
    r = '0;
    for (int p = 3; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == i) r = 7'(p);
        n++;
      end
    end
    return r;
  endfunction

  // Each check bit k collects the data bits whose position has
  // bit k set, so XOR-ing the positions of all set bits yields c.
  always_comb begin
    w_c = '0;
    for (int i = 0; i < 64; i++) begin
      if (in_data[i]) w_c = w_c ^ f_pos(i);
    end
    w_p  = (^in_data) ^ (^w_c);
    w_cw = {in_data, w_p, w_c};
  end

  assign w_accept   = in_valid && r_in_ready;
  assign w_last     = (r_state == S_SHIFT) && (r_cnt == 7'd71);
  assign w_gap_done = (r_state == S_GAP) &&
                      (r_gap == 16'(GAP_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_last) begin
          w_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP:   if (w_gap_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_in_ready_n = (w_next == S_IDLE);
    w_busy_n     = (w_next != S_IDLE);
    w_sv_n       = (w_next == S_SHIFT);
    w_sof_n      = (r_state == S_IDLE) && w_accept;
    w_so_n       = 1'b0;
    if (w_sof_n) begin
      w_so_n = w_cw[71];
    end else if (r_state == S_SHIFT && !w_last) begin
      w_so_n = r_sr[71];
    end
  end

  // r_sr runs one bit ahead of serial_out so the registered
  // output already carries cw[71] in the cycle after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_gap      <= '0;
      r_in_ready <= 1'b1;
      r_so       <= 1'b0;
      r_sv       <= 1'b0;
      r_sof      <= 1'b0;
      r_check    <= '0;
      r_busy     <= 1'b0;
      r_frames   <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= w_in_ready_n;
      r_so       <= w_so_n;
      r_sv       <= w_sv_n;
      r_sof      <= w_sof_n;
      r_busy     <= w_busy_n;
      if (w_sof_n) begin
        r_sr    <= {w_cw[70:0], 1'b0};
        r_cnt   <= '0;
        r_check <= w_cw[7:0];
      end else if (r_state == S_SHIFT && !w_last) begin
        r_sr  <= {r_sr[70:0], 1'b0};
        r_cnt <= r_cnt + 7'd1;
      end
      if (w_last) r_frames <= r_frames + 1'b1;
      if (r_state == S_GAP) r_gap <= r_gap + 16'd1;
      else                  r_gap <= '0;
    end
  end

  assign in_ready     = r_in_ready;
  assign serial_out   = r_so;
  assign serial_valid = r_sv;
  assign sof          = r_sof;
  assign check_out    = r_check;
  assign busy         = r_busy;
  assign frames_sent  = r_frames;

endmodule

// File: tb/tb_hamming_secded_encoder_72bit.sv
// Bench for hamming_secded_encoder_72bit: default build plus
// a GAP_CYCLES=0 / CNT_W=4 build, checked against a codeword model.
module tb_hamming_secded_encoder_72bit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        serial_out;
  logic        serial_valid;
  logic        sof;
  logic [7:0]  check_out;
  logic        busy;
  logic [15:0] frames_sent;

  logic [63:0] d1;
  logic        v1;
  logic        rdy1;
  logic        so1;
  logic        sv1;
  logic        sof1;
  logic [7:0]  chk1;
  logic        busy1;
  logic [3:0]  fs1;

  int n_checks = 0;
  int n_pass   = 0;
  int fs_exp   = 0;

  always #5 clk = ~clk;

  hamming_secded_encoder_72bit dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .sof          (sof),
    .check_out    (check_out),
    .busy         (busy),
    .frames_sent  (frames_sent)
  );

  hamming_secded_encoder_72bit #(
    .GAP_CYCLES (0),
    .CNT_W      (4)
  ) dut1 (
    .clk          (clk),
    .reset        (reset),
    .in_data      (d1),
    .in_valid     (v1),
    .in_ready     (rdy1),
    .serial_out   (so1),
    .serial_valid (sv1),
    .sof          (sof1),
    .check_out    (chk1),
    .busy         (busy1),
    .frames_sent  (fs1)
  );

  // Codeword from the textual rules: place data at non-power-of-two
  // Hamming positions, form each check bit over positions with bit k
  // set, then add overall even parity.
  function automatic logic [71:0] ref_cw(input logic [63:0] d);
    logic [71:0] h;
    logic [6:0]  c;
    logic        par;
    int          j;
    h = '0;
    j = 0;
    for (int p = 1; p < 72; p++) begin
      if ($countones(p) > 1) begin
        h[p] = d[j];
        j++;
      end
    end
    c = '0;
    for (int k = 0; k < 7; k++) begin
      for (int p = 1; p < 72; p++) begin
        if (((p >> k) & 1) == 1) c[k] = c[k] ^ h[p];
      end
    end
    par = 1'b0;
    for (int i = 0; i < 64; i++) par = par ^ d[i];
    for (int k = 0; k < 7; k++) par = par ^ c[k];
    return {d, par, c};
  endfunction

  task automatic chk(input string tag,
                     input logic [71:0] obs,
                     input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_frame(input logic [63:0] d,
                           input bit hold,
                           output logic [71:0] got);
    int          guard;
    int          bad;
    logic [71:0] e;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", 72'(in_ready), 72'(1'b1));
    in_data  = d;
    in_valid = 1'b1;
    e = ref_cw(d);
    @(negedge clk);
    chk("sof_first", 72'(sof), 72'(1'b1));
    chk("check_out", 72'(check_out), 72'(e[7:0]));
    chk("busy_shift", 72'({busy, in_ready}), 72'(2'b10));
    if (!hold) begin
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
    end
    got = '0;
    bad = 0;
    for (int k = 0; k < 72; k++) begin
      if (k > 0) @(negedge clk);
      got = {got[70:0], serial_out};
      if (serial_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      if (k > 0 && sof !== 1'b0) bad++;
    end
    chk("stream", got, e);
    chk("frame_ctl", 72'(bad), 72'(0));
    fs_exp++;
    @(negedge clk);
    chk("gap", 72'({serial_valid, serial_out, in_ready, busy}),
        72'(4'b0001));
    chk("frames_sent", 72'(frames_sent), 72'(16'(fs_exp)));
    @(negedge clk);
    chk("idle", 72'({in_ready, busy}), 72'(2'b10));
  endtask

  initial begin
    logic [71:0] got;
    logic [71:0] e;
    logic [63:0] d;
    logic [63:0] q[$];
    logic [71:0] sh;
    int          bits;
    int          low;
    int          frames;
    int          bad_gap;
    int          bad_frm;
    int          cyc;
    bit          started;
    bit          pushed;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    v1       = 1'b0;
    d1       = '0;
    repeat (2) @(negedge clk);

    chk("rst_outs", 72'({in_ready, serial_out, serial_valid,
                         sof, busy}), 72'(5'b10000));
    chk("rst_check", 72'(check_out), 72'(8'h00));
    chk("rst_frames", 72'(frames_sent), 72'(16'h0));
    chk("rst_dut1", 72'({rdy1, fs1}), 72'(5'b10000));
    reset = 1'b0;
    @(negedge clk);

    run_frame(64'h0, 1'b0, got);
    chk("chk_zero", 72'(check_out), 72'(8'h00));
    chk("stream_zero", got, 72'h0);

    run_frame(64'h1, 1'b0, got);
    chk("chk_one", 72'(check_out), 72'(8'h83));
    chk("stream_one", got, {64'h1, 8'h83});

    // in_valid stays high: the second word goes in on the first
    // IDLE cycle after the gap.
    run_frame(64'h2, 1'b1, got);
    chk("chk_two", 72'(check_out), 72'(8'h85));
    run_frame(64'h2, 1'b0, got);
    chk("stream_two", got, {64'h2, 8'h85});

    run_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, got);
    for (int n = 0; n < 40; n++) begin
      run_frame({$urandom, $urandom}, 1'b0, got);
    end

    // Abort in the middle of a frame.
    d = {$urandom, $urandom};
    e = ref_cw(d);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (41) @(negedge clk);
    chk("bit30", 72'(serial_out), 72'(e[30]));
    reset = 1'b1;
    #1;
    chk("abort_outs", 72'({in_ready, serial_out, serial_valid,
                           sof, busy}), 72'(5'b10000));
    chk("abort_frames", 72'(frames_sent), 72'(16'h0));
    chk("abort_check", 72'(check_out), 72'(8'h00));
    @(negedge clk);
    reset  = 1'b0;
    fs_exp = 0;
    @(negedge clk);
    run_frame({$urandom, $urandom}, 1'b0, got);

    // GAP_CYCLES=0, CNT_W=4 build, back-to-back words.
    bits    = 0;
    low     = 0;
    frames  = 0;
    bad_gap = 0;
    bad_frm = 0;
    cyc     = 0;
    started = 1'b0;
    pushed  = 1'b0;
    sh      = '0;
    d1      = {$urandom, $urandom};
    v1      = 1'b1;
    if (rdy1) begin
      q.push_back(d1);
      pushed = 1'b1;
    end
    while (frames < 17 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (pushed) begin
        d1     = {$urandom, $urandom};
        pushed = 1'b0;
      end
      if (sv1) begin
        if (started && bits == 0 && low != 1) bad_gap++;
        sh = {sh[70:0], so1};
        bits++;
        if (bits == 72) begin
          if (q.size() == 0) bad_frm++;
          else if (sh !== ref_cw(q.pop_front())) bad_frm++;
          frames++;
          bits    = 0;
          low     = 0;
          started = 1'b1;
          if (frames == 17) v1 = 1'b0;
        end
      end else if (started) begin
        low++;
      end
      if (rdy1 && v1) begin
        q.push_back(d1);
        pushed = 1'b1;
      end
    end
    v1 = 1'b0;
    chk("g0_frames_seen", 72'(frames), 72'(17));
    chk("g0_streams", 72'(bad_frm), 72'(0));
    chk("g0_gaps", 72'(bad_gap), 72'(0));
    @(negedge clk);
    chk("g0_wrap", 72'(fs1), 72'(4'd1));
    chk("g0_idle", 72'({rdy1, sv1, busy1}), 72'(3'b100));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hamming_secded_encoder_72bit.md
Name: hamming_secded_encoder_72bit

Overview:
- Upstream partner of the 72-bit extended Hamming serial decoder: accepts a 64-bit data word over a valid/ready handshake, computes 8 SECDED check bits, and serializes the 72-bit codeword MSB-first onto a single-bit line.
- Inserts the inter-frame idle gap the decoder needs: it spends one cycle per frame on syndrome evaluation without sampling its serial input.
- Sits between the data source and the serial channel (or the decoder directly in loopback).

Parameters:
- GAP_CYCLES, 1: idle cycles (serial_valid=0, serial_out=0) inserted after every 72-bit frame; 0 is legal.
- CNT_W, 16: width of frames_sent counter.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  64  data word to encode
- in_valid  input  1  in_data valid
- in_ready  output  1  encoder can accept a word
- serial_out  output  1  serial codeword bit, MSB (bit 71) first
- serial_valid  output  1  serial_out carries a codeword bit
- sof  output  1  one-cycle pulse coincident with codeword bit 71
- check_out  output  8  check bits of the frame currently or last shifted
- busy  output  1  high in SHIFT or GAP
- frames_sent  output  CNT_W  count of completed frames, wraps modulo 2^CNT_W

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk. All outputs are registered.
- Reset values: in_ready=1, serial_out=0, serial_valid=0, sof=0, check_out=0, busy=0, frames_sent=0, state=IDLE, bit counter=0, shift register=0.
- Codeword layout: cw[71:8]=in_data[63:0]; cw[7]=overall parity; cw[6:0]=c[6:0].
- Hamming positions 1..71: data bit i occupies the i-th non-power-of-two position in ascending order (data[0]->3, data[1]->5, data[2]->6, data[3]->7, data[4]->9, ..., data[63]->71).
- c[k] = XOR of all data bits whose position has bit k set (k=0..6).
- cw[7] = XOR of in_data[63:0] and c[6:0], giving even overall parity over all 72 bits.
- Check bits are computed combinationally from in_data and registered at acceptance together with the data.

FSM (IDLE, SHIFT, GAP):
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load shift register with cw, latch check_out, clear the bit counter, go to SHIFT.
  - in_ready drops in the same edge.
- SHIFT:
  - Each cycle drives serial_out=sr[71], serial_valid=1, then shifts left.
  - The first SHIFT cycle (the cycle after acceptance) presents cw[71] with sof=1; sof=0 on all other cycles.
  - Exactly 72 cycles.
  - After the cycle carrying cw[0], frames_sent increments and the FSM goes to GAP, or to IDLE if GAP_CYCLES=0.
- GAP:
  - serial_valid=0, serial_out=0, in_ready=0 for GAP_CYCLES cycles, then IDLE.
- Latency: acceptance edge N -> cw[71] on serial_out during cycle N+1 -> cw[0] during cycle N+72.
- Throughput: one word per 72+GAP_CYCLES+1 cycles; the +1 is the IDLE acceptance cycle.
- in_valid while in_ready=0 is ignored; upstream holds its data. in_data is not sampled after acceptance, so changing it mid-frame has no effect.
- frames_sent wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-frame: the frame is aborted immediately and all outputs return to their reset values. No partial frame resumes after reset.
- Bit counter is 7 bits; terminal value 71. Counter values beyond 71 are unreachable.

Test Plan:
- Reset, in_data=64'h0 accepted -> check_out=8'h00; 72 serial_valid cycles of serial_out=0; sof only on the first; then 1 gap cycle; frames_sent=1.
- in_data=64'h1 -> check_out=8'h83; serial stream = 63 zeros, a 1 (cw[8]), then 1,0,0,0,0,0,1,1; loopback decoder reports no error and data_out=64'h1.
- in_data=64'h2 -> check_out=8'h85; in_ready low for 72+1 cycles after acceptance; in_valid held high throughout accepts a second word on the first IDLE cycle.
- Random 1000 words in loopback through the decoder, plus one injected single-bit flip per frame at a random position -> decoded data equals sent data; error_corrected=1 on flipped frames.
- Assert reset at bit 30 of a frame -> serial_valid=0, in_ready=1, frames_sent unchanged (0) on the next edge; the following accepted word is serialized complete from cw[71].
- GAP_CYCLES=0 build: back-to-back words -> serial_valid low for exactly 1 cycle between frames. CNT_W=4 build: 17 frames -> frames_sent=1.
